// File: rtl/qos_emisor.sv
`default_nettype none
// ============================================================================
// Module      : qos_emisor
// Description : Upstream transmitter for the qos ingress. Holds one word per
//               virtual channel, arbitrates round-robin among eligible VCs,
//               honours pausa/continuar flow control and retransmits words
//               rejected through error_full.
// Revision    : 1.0 - initial release
// ============================================================================
module qos_emisor #(
  parameter int QUEUE_QUANTITY = 4,
  parameter int BUF_WIDTH      = 3,
  parameter int CNT_BITS       = 16
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     enb,
  input  logic [QUEUE_QUANTITY-1:0]                src_valid,
  input  logic [QUEUE_QUANTITY*(BUF_WIDTH+1)-1:0]  src_data,
  output logic [QUEUE_QUANTITY-1:0]                src_ready,
  input  logic [QUEUE_QUANTITY-1:0]                pausa,
  input  logic [QUEUE_QUANTITY-1:0]                continuar,
  input  logic [QUEUE_QUANTITY-1:0]                error_full,
  output logic                                     push,
  output logic [$clog2(QUEUE_QUANTITY)-1:0]        vc_id,
  output logic [BUF_WIDTH:0]                       data_word,
  output logic [QUEUE_QUANTITY-1:0]                vc_pausado,
  output logic                                     idle,
  output logic [CNT_BITS-1:0]                      words_sent
);

  localparam int c_DW = BUF_WIDTH + 1;
  localparam int c_VW = $clog2(QUEUE_QUANTITY);

  // Per-VC holding slot life cycle
  typedef enum logic [1:0] {
    VACIO    = 2'd0,
    LLENO    = 2'd1,
    ENVIADO  = 2'd2,
    CONFIRMA = 2'd3
  } slot_e;

  slot_e                     slot_q [QUEUE_QUANTITY];
  slot_e                     slot_d [QUEUE_QUANTITY];
  logic [c_DW-1:0]           data_q [QUEUE_QUANTITY];
  logic [c_DW-1:0]           data_d [QUEUE_QUANTITY];
  logic [QUEUE_QUANTITY-1:0] pausado_q, pausado_d;
  logic [c_VW-1:0]           ptr_q, ptr_d;
  logic                      push_q;
  logic [c_VW-1:0]           vc_id_q;
  logic [c_DW-1:0]           data_word_q;
  logic [CNT_BITS-1:0]       words_sent_q;

  logic [QUEUE_QUANTITY-1:0] w_cand;
  logic                      w_grant_any;
  logic [c_VW-1:0]           w_grant_vc;
  logic [c_VW-1:0]           w_idx;
  logic                      w_confirm;

  // A VC competes only while it holds an unsent word, is not paused and enb is high
  always_comb begin
    w_cand = '0;
    for (int v = 0; v < QUEUE_QUANTITY; v++) begin
      w_cand[v] = enb && (slot_q[v] == LLENO) && !pausado_q[v];
    end
  end

  // Round-robin search starting at the pointer, ascending with wrap
  always_comb begin
    w_grant_any = 1'b0;
    w_grant_vc  = '0;
    w_idx       = '0;
    ptr_d       = ptr_q;
    for (int i = 0; i < QUEUE_QUANTITY; i++) begin
      w_idx = c_VW'((int'(ptr_q) + i) % QUEUE_QUANTITY);
      if (!w_grant_any && w_cand[w_idx]) begin
        w_grant_any = 1'b1;
        w_grant_vc  = w_idx;
      end
    end
    if (w_grant_any) begin
      ptr_d = c_VW'((int'(w_grant_vc) + 1) % QUEUE_QUANTITY);
    end
  end

  // Slot next-state, data capture, pause flags and confirm detection
  always_comb begin
    pausado_d = pausado_q;
    w_confirm = 1'b0;
    for (int v = 0; v < QUEUE_QUANTITY; v++) begin
      slot_d[v] = slot_q[v];
      data_d[v] = data_q[v];
    end
    for (int v = 0; v < QUEUE_QUANTITY; v++) begin
      // pausa dominates continuar when both arrive together
      if (pausa[v]) begin
        pausado_d[v] = 1'b1;
      end else if (continuar[v]) begin
        pausado_d[v] = 1'b0;
      end
      case (slot_q[v])
        VACIO: begin
          if (src_valid[v]) begin
            slot_d[v] = LLENO;
            data_d[v] = src_data[v*c_DW +: c_DW];
          end
        end
        LLENO: begin
          if (w_grant_any && (w_grant_vc == c_VW'(v))) begin
            slot_d[v] = ENVIADO;
          end
        end
        ENVIADO: begin
          slot_d[v] = CONFIRMA;
        end
        CONFIRMA: begin
          if (error_full[v]) begin
            // Rejected word stays held and the VC waits for continuar
            slot_d[v]    = LLENO;
            pausado_d[v] = 1'b1;
          end else begin
            slot_d[v] = VACIO;
            w_confirm = 1'b1;
          end
        end
        default: slot_d[v] = VACIO;
      endcase
    end
  end

  // Slot, pause flag and arbiter pointer registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int v = 0; v < QUEUE_QUANTITY; v++) begin
        slot_q[v] <= VACIO;
        data_q[v] <= '0;
      end
      pausado_q <= '0;
      ptr_q     <= '0;
    end else begin
      for (int v = 0; v < QUEUE_QUANTITY; v++) begin
        slot_q[v] <= slot_d[v];
        data_q[v] <= data_d[v];
      end
      pausado_q <= pausado_d;
      ptr_q     <= ptr_d;
    end
  end

  // Registered ingress interface and confirmed-word counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      push_q       <= 1'b0;
      vc_id_q      <= '0;
      data_word_q  <= '0;
      words_sent_q <= '0;
    end else begin
      push_q <= w_grant_any;
      if (w_grant_any) begin
        vc_id_q     <= w_grant_vc;
        data_word_q <= data_q[w_grant_vc];
      end
      words_sent_q <= words_sent_q + {{(CNT_BITS-1){1'b0}}, w_confirm};
    end
  end

  // Ready and idle status derived from registered state
  always_comb begin
    src_ready = '0;
    for (int v = 0; v < QUEUE_QUANTITY; v++) begin
      src_ready[v] = (slot_q[v] == VACIO);
    end
    idle = (&src_ready) && !push_q;
  end

  assign push       = push_q;
  assign vc_id      = vc_id_q;
  assign data_word  = data_word_q;
  assign vc_pausado = pausado_q;
  assign words_sent = words_sent_q;

endmodule
`default_nettype wire

// File: tb/tb_qos_emisor.sv
`default_nettype none
// ============================================================================
// Module      : tb_qos_emisor
// Description : Self-checking bench for qos_emisor. A transaction-level model
//               tracks each VC's held word, its confirm deadline and pause
//               flag, and predicts every output once per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_qos_emisor;

  localparam int Q  = 4;
  localparam int BW = 3;
  localparam int DW = BW + 1;
  localparam int CB = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            enb;
  logic [Q-1:0]    src_valid;
  logic [Q*DW-1:0] src_data;
  logic [Q-1:0]    src_ready;
  logic [Q-1:0]    pausa;
  logic [Q-1:0]    continuar;
  logic [Q-1:0]    error_full;
  logic            push;
  logic [1:0]      vc_id;
  logic [DW-1:0]   data_word;
  logic [Q-1:0]    vc_pausado;
  logic            idle;
  logic [CB-1:0]   words_sent;

  // Free-running clock
  always #5 clk = ~clk;

  qos_emisor #(.QUEUE_QUANTITY(Q), .BUF_WIDTH(BW), .CNT_BITS(CB)) dut (
    .clk        (clk),
    .rst        (rst),
    .enb        (enb),
    .src_valid  (src_valid),
    .src_data   (src_data),
    .src_ready  (src_ready),
    .pausa      (pausa),
    .continuar  (continuar),
    .error_full (error_full),
    .push       (push),
    .vc_id      (vc_id),
    .data_word  (data_word),
    .vc_pausado (vc_pausado),
    .idle       (idle),
    .words_sent (words_sent)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  // Reference model state: word held, word handed to qos, confirm cycle, pause
  bit            m_has    [Q];
  bit            m_sent   [Q];
  bit            m_paused [Q];
  int            m_conf   [Q];
  logic [DW-1:0] m_word   [Q];
  int            m_ptr;
  bit            m_push;
  int            m_vc;
  logic [DW-1:0] m_dw;
  int            m_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int v = 0; v < Q; v++) begin
      m_has[v] = 0; m_sent[v] = 0; m_paused[v] = 0; m_conf[v] = 0; m_word[v] = '0;
    end
    m_ptr = 0; m_push = 0; m_vc = 0; m_dw = '0; m_cnt = 0;
  endtask

  // Predict the state after the coming rising edge from the inputs now driven
  task automatic model_step();
    bit old_has [Q];
    bit retry   [Q];
    int g;
    if (!rst) begin
      model_reset();
      return;
    end
    g = -1;
    for (int v = 0; v < Q; v++) begin
      old_has[v] = m_has[v];
      retry[v]   = 0;
    end
    if (enb) begin
      for (int i = 0; i < Q; i++) begin
        int v;
        v = (m_ptr + i) % Q;
        if (g < 0 && m_has[v] && !m_sent[v] && !m_paused[v]) g = v;
      end
    end
    for (int v = 0; v < Q; v++) begin
      if (m_has[v] && m_sent[v] && m_conf[v] == cyc) begin
        if (error_full[v]) begin
          m_sent[v] = 0;
          retry[v]  = 1;
        end else begin
          m_has[v] = 0;
          m_cnt    = (m_cnt + 1) % 65536;
        end
      end
    end
    for (int v = 0; v < Q; v++) begin
      if (pausa[v]) m_paused[v] = 1;
      else if (continuar[v]) m_paused[v] = 0;
      if (retry[v]) m_paused[v] = 1;
    end
    if (g >= 0) begin
      m_sent[g] = 1;
      m_conf[g] = cyc + 2;
      m_push    = 1;
      m_vc      = g;
      m_dw      = m_word[g];
      m_ptr     = (g + 1) % Q;
    end else begin
      m_push = 0;
    end
    for (int v = 0; v < Q; v++) begin
      if (!old_has[v] && src_valid[v]) begin
        m_has[v]  = 1;
        m_sent[v] = 0;
        m_word[v] = src_data[v*DW +: DW];
      end
    end
  endtask

  task automatic compare_all();
    logic [Q-1:0] exp_p, exp_r;
    bit           all_free;
    all_free = 1;
    for (int v = 0; v < Q; v++) begin
      exp_p[v] = m_paused[v];
      exp_r[v] = !m_has[v];
      if (m_has[v]) all_free = 0;
    end
    check("push",       push,       m_push);
    check("vc_id",      vc_id,      m_vc);
    check("data_word",  data_word,  m_dw);
    check("vc_pausado", vc_pausado, exp_p);
    check("src_ready",  src_ready,  exp_r);
    check("idle",       idle,       all_free && !m_push);
    check("words_sent", words_sent, m_cnt[CB-1:0]);
  endtask

  // One clock cycle: predict, advance, then sample on the falling edge
  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    compare_all();
  endtask

  task automatic quiet();
    enb = 1'b1; src_valid = '0; src_data = '0;
    pausa = '0; continuar = '0; error_full = '0;
  endtask

  initial begin
    rst = 1'b0;
    quiet();
    model_reset();
    @(negedge clk);
    tick();
    // Reset state against fixed constants
    check("rst_push",  push,       1'b0);
    check("rst_vc",    vc_id,      2'd0);
    check("rst_data",  data_word,  4'd0);
    check("rst_cnt",   words_sent, 16'd0);
    check("rst_ready", src_ready,  4'b1111);
    check("rst_idle",  idle,       1'b1);
    rst = 1'b1;
    tick();

    // Single word on VC2: accepted in k, pushed in k+2, confirmed in k+3
    src_valid = 4'b0100;
    src_data  = 16'h0500;
    tick();
    quiet();
    tick();
    check("sw_push", push,      1'b1);
    check("sw_vc",   vc_id,     2'd2);
    check("sw_data", data_word, 4'd5);
    tick();
    check("sw_ready_k4", src_ready[2], 1'b0);
    tick();
    check("sw_cnt",   words_sent,   16'd1);
    check("sw_ready", src_ready[2], 1'b1);
    check("sw_idle",  idle,         1'b1);

    // All VCs offering continuously with no rejections
    src_valid = 4'b1111;
    for (int i = 0; i < 16; i++) begin
      src_data = 16'($urandom);
      tick();
    end
    quiet();
    for (int i = 0; i < 4; i++) tick();

    // Randomized traffic with flow control, rejections, enb gaps and resets
    for (int i = 0; i < 4000; i++) begin
      rst        = ($urandom_range(0, 399) != 0);
      enb        = ($urandom_range(0, 7) != 0);
      src_valid  = 4'($urandom);
      src_data   = 16'($urandom);
      for (int v = 0; v < Q; v++) begin
        pausa[v]      = ($urandom_range(0, 15) == 0);
        continuar[v]  = ($urandom_range(0, 3) == 0);
        error_full[v] = ($urandom_range(0, 2) == 0);
      end
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
